// File: rtl/cpu_hatch_server_pkg.sv
// cpu_hatch_server_pkg: shared widths and loader state encoding for the hatch server
package cpu_hatch_server_pkg;
  localparam int INSTR_W = 48;
  localparam int BYTES_PER_WORD = 6;
  typedef enum logic [1:0] {HOLD, LOAD, RUN} state_t;
endpackage

// File: rtl/cpu_hatch_server_if.sv
// cpu_hatch_server_if: fetch hatch (hatch_address/hatch_instruction) plus host byte loader (load_*), master = fetch/host side
interface cpu_hatch_server_if
  import cpu_hatch_server_pkg::*;
#(
  parameter int ADDR_W = 11
);
  logic [31:0]        hatch_address;
  logic [INSTR_W-1:0] hatch_instruction;
  logic               load_start;
  logic               load_done;
  logic [7:0]         load_byte;
  logic               load_valid;
  logic               load_ready;
  logic [ADDR_W:0]    load_count;
  logic               load_error;
  modport master (
    output hatch_address, load_start, load_done, load_byte, load_valid,
    input  hatch_instruction, load_ready, load_count, load_error
  );
  modport slave (
    input  hatch_address, load_start, load_done, load_byte, load_valid,
    output hatch_instruction, load_ready, load_count, load_error
  );
endinterface

// File: rtl/cpu_hatch_ram.sv
// cpu_hatch_ram: 1W1R DEPTH x 48 instruction store, registered read, array not reset (clk, we/waddr/wdata, raddr/rdata)
module cpu_hatch_ram
  import cpu_hatch_server_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int DEPTH  = 2048
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [INSTR_W-1:0] rdata
);
  logic [INSTR_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/cpu_hatch_server.sv
// cpu_hatch_server: serves hatch reads from the instruction store and fills it from a host byte stream (clk, rst_b, bus slave, cpu_rst_b)
module cpu_hatch_server
  import cpu_hatch_server_pkg::*;
#(
  parameter int                 ADDR_W    = 11,
  parameter int                 DEPTH     = 2048,
  parameter logic [INSTR_W-1:0] HALT_WORD = '0
) (
  input  logic                 clk,
  input  logic                 rst_b,
  cpu_hatch_server_if.slave    bus,
  output logic                 cpu_rst_b
);
  state_t             state_q, state_d;
  logic [ADDR_W:0]    ptr_q, ptr_d;
  logic [2:0]         idx_q, idx_d;
  logic [39:0]        asm_q, asm_d;
  logic               err_q, err_d;
  logic               cpu_rst_b_q, cpu_rst_b_d;
  logic               halt_q, halt_d;
  logic               full, xfer, we;
  logic [INSTR_W-1:0] rdata;
  assign full = ptr_q[ADDR_W];
  // start/done pulses take priority over a byte offered in the same cycle
  assign xfer = bus.load_valid && state_q == LOAD && !full && !bus.load_start && !bus.load_done;
  assign we   = xfer && idx_q == 3'(BYTES_PER_WORD - 1);
  always_comb begin
    state_d     = bus.load_start ? LOAD : bus.load_done ? RUN : state_q;
    ptr_d       = bus.load_start ? '0 : ptr_q + {{ADDR_W{1'b0}}, we};
    idx_d       = (bus.load_start || bus.load_done || we) ? '0 : idx_q + {2'b0, xfer};
    err_d       = bus.load_start ? 1'b0 :
                  err_q || (bus.load_done && idx_q != '0) || (state_q == LOAD && full && bus.load_valid);
    cpu_rst_b_d = state_d == RUN;
    halt_d      = state_q != RUN || |bus.hatch_address[31:ADDR_W];
    asm_d       = asm_q;
    for (int i = 0; i < BYTES_PER_WORD - 1; i++)
      asm_d[i*8 +: 8] = (xfer && idx_q == 3'(i)) ? bus.load_byte : asm_q[i*8 +: 8];
  end
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= HOLD;
      ptr_q       <= '0;
      idx_q       <= '0;
      asm_q       <= '0;
      err_q       <= 1'b0;
      cpu_rst_b_q <= 1'b0;
      halt_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      idx_q       <= idx_d;
      asm_q       <= asm_d;
      err_q       <= err_d;
      cpu_rst_b_q <= cpu_rst_b_d;
      halt_q      <= halt_d;
    end
  end
  cpu_hatch_ram #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (ptr_q[ADDR_W-1:0]),
    .wdata ({bus.load_byte, asm_q}),
    .raddr (bus.hatch_address[ADDR_W-1:0]),
    .rdata (rdata)
  );
  assign bus.hatch_instruction = halt_q ? HALT_WORD : rdata;
  assign bus.load_ready        = state_q == LOAD && !full;
  assign bus.load_count        = ptr_q;
  assign bus.load_error        = err_q;
  assign cpu_rst_b             = cpu_rst_b_q;
endmodule
